// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation, framing-error
// detection and an 8-entry first-word-fall-through receive FIFO, all in the crystal domain.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                clk_xtal,
  input  logic                                rst_n,
  input  logic [23:0]                         baud,
  input  logic                                rx,
  input  logic                                read,
  input  logic                                clr_err,
  output logic [7:0]                          DataIn,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                overrun,
  output logic                                frame_err
);

  localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [SAMP_W-1:0] MID_TICK  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] LAST_TICK = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic                rx_m_q, rx_s_q;
  logic [31:0]         tick_cnt_q, tick_cnt_d;
  logic [31:0]         den_c, quot_c, div_c;
  logic                tick_c;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                push_q, push_d;
  logic                frame_set_c;

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, full_q, overrun_q, frame_err_q;
  logic                pop_c, wr_c, ovf_c;

  // Baud divider; a zero quotient (baud=0 or too fast) clamps to 1.
  always_comb begin
    den_c  = 32'(OVERSAMPLE) * 32'(baud);
    quot_c = (den_c == 32'd0) ? 32'd0 : 32'(CLK_HZ) / den_c;
    div_c  = (quot_c == 32'd0) ? 32'd1 : quot_c;
    tick_c = (tick_cnt_q >= div_c - 32'd1);
    tick_cnt_d = tick_c ? 32'd0 : tick_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_xtal) begin
    if (!rst_n) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
    end else begin
      rx_m_q     <= rx;
      rx_s_q     <= rx_m_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
    end
  end

  // Frame sequencer: sub-tick count restarts at start detect, samples at mid-bit.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        samp_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick_c) begin
          if (samp_q == MID_TICK) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          samp_d = samp_q + SAMP_W'(1);
          if (samp_q == LAST_TICK) begin
            shift_d[bit_q] = rx_s_q;
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick_c) begin
          samp_d = samp_q + SAMP_W'(1);
          if (samp_q == LAST_TICK) begin
            if (rx_s_q) begin
              push_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_set_c = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a pop on full makes room for the same-cycle push.
  always_comb begin
    pop_c   = read && !empty_q;
    wr_c    = push_q && (!full_q || pop_c);
    ovf_c   = push_q && full_q && !pop_c;
    count_d = count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk_xtal) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == DEPTH_CNT);
      overrun_q   <= ovf_c ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
      frame_err_q <= frame_set_c ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    end
  end

  always_ff @(posedge clk_xtal) begin
    if (wr_c) mem_q[wr_ptr_q] <= shift_q;
  end

  assign DataIn    = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 115200 baud (224 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 224;

  logic        clk_xtal = 1'b0;
  logic        rst_n;
  logic [23:0] baud;
  logic        rx;
  logic        read;
  logic        clr_err;
  logic [7:0]  DataIn;
  logic        empty, full;
  logic [3:0]  count;
  logic        overrun, frame_err;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo dut (
    .clk_xtal  (clk_xtal),
    .rst_n     (rst_n),
    .baud      (baud),
    .rx        (rx),
    .read      (read),
    .clr_err   (clr_err),
    .DataIn    (DataIn),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk_xtal = ~clk_xtal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_xtal);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_xtal);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk_xtal);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk_xtal);
    rx = 1'b1;
  endtask

  task automatic pop();
    read = 1'b1;
    @(negedge clk_xtal);
    read = 1'b0;
    @(negedge clk_xtal);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_xtal);
    clr_err = 1'b0;
    @(negedge clk_xtal);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; baud = 24'd115200; rx = 1'b1; read = 1'b0; clr_err = 1'b0;
    repeat (4) @(negedge clk_xtal);
    check("rst_count",  32'(count), 32'd0);
    check("rst_empty",  32'(empty), 32'd1);
    check("rst_full",   32'(full), 32'd0);
    check("rst_data",   32'(DataIn), 32'h00);
    check("rst_ovr",    32'(overrun), 32'd0);
    check("rst_ferr",   32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle(50);

    // 1: single byte and FWFT pop
    send_frame(8'h55, 1'b1);
    idle(20);
    check("t1_count", 32'(count), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_data",  32'(DataIn), 32'h55);
    pop();
    check("t1_count_after", 32'(count), 32'd0);
    check("t1_empty_after", 32'(empty), 32'd1);
    check("t1_data_after",  32'(DataIn), 32'h00);

    // 2: short low glitch is rejected
    rx = 1'b0;
    repeat (50) @(negedge clk_xtal);
    idle(2 * BIT_CLKS * 10);
    check("t2_count", 32'(count), 32'd0);
    check("t2_ferr",  32'(frame_err), 32'd0);

    // 3: framing error, recovery, clear
    send_frame(8'hA3, 1'b0);
    idle(300);
    check("t3_ferr",  32'(frame_err), 32'd1);
    check("t3_count", 32'(count), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("t3_count2", 32'(count), 32'd1);
    check("t3_data2",  32'(DataIn), 32'h3C);
    check("t3_ferr_held", 32'(frame_err), 32'd1);
    pulse_clr();
    check("t3_ferr_clr", 32'(frame_err), 32'd0);
    pop();
    check("t3_empty", 32'(empty), 32'd1);

    // 4: nine back-to-back frames overflow the FIFO
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    idle(2);
    check("t4_full8",  32'(full), 32'd1);
    check("t4_count8", 32'(count), 32'd8);
    check("t4_ovr8",   32'(overrun), 32'd0);
    send_frame(8'h08, 1'b1);
    idle(20);
    check("t4_ovr9",   32'(overrun), 32'd1);
    check("t4_count9", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_read%0d", i), 32'(DataIn), 32'(i));
      pop();
    end
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_count0", 32'(count), 32'd0);

    // 5: pop coincident with push while full
    pulse_clr();
    check("t5_ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(2);
    check("t5_full", 32'(full), 32'd1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        int waited = 0;
        while (dut.push_q !== 1'b1 && waited < 4000) begin
          @(negedge clk_xtal);
          waited++;
        end
        check("t5_push_seen", 32'(dut.push_q), 32'd1);
        check("t5_head", 32'(DataIn), 32'h10);
        read = 1'b1;
        @(negedge clk_xtal);
        read = 1'b0;
      end
    join
    idle(20);
    check("t5_count", 32'(count), 32'd8);
    check("t5_ovr",   32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_read%0d", i), 32'(DataIn), (i == 7) ? 32'h99 : 32'h11 + 32'(i));
      pop();
    end
    check("t5_empty", 32'(empty), 32'd1);

    // 6: reset mid-frame abandons the frame and clears the FIFO
    send_frame(8'h77, 1'b1);
    idle(20);
    check("t6_pre_count", 32'(count), 32'd1);
    rx = 1'b0;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk_xtal);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk_xtal);
    rst_n = 1'b1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full",  32'(full), 32'd0);
    check("t6_data",  32'(DataIn), 32'h00);
    check("t6_ovr",   32'(overrun), 32'd0);
    check("t6_ferr",  32'(frame_err), 32'd0);
    idle(3000);
    check("t6_no_push", 32'(count), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("t6_count2", 32'(count), 32'd1);
    check("t6_data2",  32'(DataIn), 32'h3C);
    check("t6_ferr2",  32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Standalone UART receiver with 16x oversampling, start-bit validation, framing-error detection and an 8-entry receive FIFO toward the CPU. It is the receiving end for the project's 8N1 UART transmit path. It replaces the single-byte, baud-clocked receive latch with a design running entirely in the crystal domain. The CPU reads bytes through a first-word-fall-through interface with a one-cycle pop strobe.

Parameters:
CLK_HZ, 27000000, crystal clock frequency in Hz
OVERSAMPLE, 16, sample ticks per bit (fixed; mid-bit = tick 7)
FIFO_DEPTH, 8, receive FIFO entries (power of two)

Ports:
clk_xtal  input  1  27 MHz clock; the only clock
rst_n  input  1  synchronous active-low reset
baud  input  24  baud rate in bit/s; sampled continuously
rx  input  1  asynchronous serial line, idle high
read  input  1  pop strobe, one clk_xtal cycle per byte
clr_err  input  1  clears sticky overrun/frame_err
DataIn  output  8  FIFO head byte; 0 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  4  bytes in FIFO, 0..8
overrun  output  1  sticky: byte dropped because FIFO full
frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (rst_n=0 at a clk_xtal edge): FSM=IDLE, tick/bit counters 0, FIFO pointers 0, count=0, empty=1, full=0, DataIn=0, overrun=0, frame_err=0, synchronizer flops=1. Reset mid-frame abandons the frame; no partial byte is pushed.
- Tick generator: div = CLK_HZ/(OVERSAMPLE*baud), integer truncation. div=0 (including baud=0 or baud too high) clamps to 1. The counter runs 0..div-1 and emits a 1-cycle tick on wrap. It runs freely, and the FSM restarts its own sub-tick count at start detect.
- rx passes through a 2-flop synchronizer (rx_s). Start detection uses rx_s.
- FSM:
  - IDLE: rx_s==0 -> START, clear sample counter.
  - START: on tick 7, rx_s==0 -> DATA, bit=0; rx_s==1 -> IDLE (glitch rejected, nothing flagged).
  - DATA: each 16 ticks after the start mid-point, sample rx_s into shift[bit], LSB first. After bit 7 -> STOP.
  - STOP: 16 ticks later, sample the stop bit. If 1, push the byte. If 0, set frame_err, discard the byte, and wait for rx_s==1 before re-arming. Return to IDLE in the same cycle so back-to-back frames are accepted.
- FIFO (FWFT):
  - DataIn = mem[rd_ptr] when !empty, else 0. Combinationally valid the cycle after a push lands.
  - read with !empty pops (rd_ptr+1 wraps mod 8). read with empty is ignored.
  - Push with full and no pop: byte dropped, overrun=1.
  - Push and pop in the same cycle: when full, both occur (count stays 8, no overrun). When empty, the push occurs and the pop is ignored. Otherwise both occur.
  - count, empty and full update on the edge after the event.
- Sticky flags: clr_err=1 clears both flags. If a set and clr_err coincide, the set wins.
- Latency: the byte is visible on DataIn 2 cycles after the stop-bit mid-sample edge (push edge plus count register).

Test Plan:
1. baud=115200 (div=14, 224 clk/bit); drive 0x55 as 8N1 -> count=1, empty=0, DataIn=0x55; one-cycle read -> count=0, empty=1, DataIn=0x00.
2. rx low for 50 clocks, then high -> FSM returns to IDLE, count=0, frame_err=0.
3. Drive 0xA3 with stop bit low -> frame_err=1, count=0; then a normal 0x3C frame -> count=1, DataIn=0x3C; pulse clr_err -> frame_err=0.
4. Nine back-to-back frames 0x00..0x08 with no reads -> full=1 after 8, overrun=1; eight reads return 0x00..0x07, then empty=1.
5. FIFO full; pulse read on the exact push cycle of frame 0x99 -> count stays 8, overrun=0; the eighth read returns 0x99.
6. Assert rst_n for 1 cycle during DATA bit 3 of 0xF0, with rx held high afterward -> all outputs at reset values, no byte pushed; next frame 0x3C is received correctly.
